lsu_dmem_master: RTL

//   CPU-side load/store initiator for the SPRAM-backed data memory. Accepts one

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_dmem_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states
// and the alignment check used by both the request path and the bench-facing top.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_RESP    = 3'd2,
      ST_SLEEP   = 3'd3,
      ST_WAKE    = 3'd4
   } lsu_state_t;

   // Size 2'b11 has no legal encoding, so it is reported like a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic w_bad;
      w_bad = 1'b0;
      case (size)
         SZ_B:    w_bad = 1'b0;
         SZ_H:    w_bad = lo[0];
         SZ_W:    w_bad = (lo != 2'b00);
         default: w_bad = 1'b1;
      endcase
      return w_bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half lane of the
// memory word and sign- or zero-extends it to 32 bits.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_addr_lo,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (i_addr_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data = i_rdata;
      case (i_size)
         SZ_B: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         SZ_H: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_dmem_master.sv
// CPU-side load/store initiator for the SPRAM data memory: lane steering, one
// outstanding access, load extension and standby/wake sequencing of the memory.
module lsu_dmem_master
   import lsu_pkg::*;
#(
   parameter int WAKE_CYCLES = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   input  logic        cpu_wfi,
   output logic [31:0] addr,
   output logic [31:0] write_data,
   output logic        memwrite,
   output logic        memread,
   output logic [3:0]  sign_mask,
   output logic        wfi,
   input  logic [31:0] read_data
);

   localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

   lsu_state_t       r_state;
   lsu_state_t       w_state_next;
   logic             r_rst_done;
   logic [31:0]      r_rdata;
   logic             r_err;
   logic             r_wfi;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [1:0]       r_addr_lo;
   logic [WCW-1:0]   r_wake_cnt;

   logic             w_accept;
   logic             w_mis;
   logic             w_strobe;
   logic [31:0]      w_load_data;

   // r_rst_done keeps req_ready low while rst_n is asserted and for the first edge after.
   assign req_ready  = (r_state == ST_IDLE) & ~cpu_wfi & r_rst_done;
   assign w_accept   = req_valid & req_ready;
   assign w_mis      = is_misaligned(req_size, req_addr[1:0]);
   assign w_strobe   = w_accept & ~w_mis;

   assign memwrite   = w_strobe & req_we;
   assign memread    = w_strobe & ~req_we;
   assign addr       = w_strobe ? req_addr : 32'h0;
   assign wfi        = r_wfi;

   assign resp_valid = (r_state == ST_RESP);
   assign resp_err   = resp_valid & r_err;
   assign resp_rdata = resp_valid ? r_rdata : 32'h0;

   always_comb begin
      sign_mask  = 4'b0000;
      write_data = 32'h0;
      if (w_strobe) begin
         case (req_size)
            SZ_B: sign_mask = 4'b0001 << req_addr[1:0];
            SZ_H: sign_mask = 4'b0011 << {req_addr[1], 1'b0};
            default: sign_mask = 4'b1111;
         endcase
      end
      if (memwrite) begin
         case (req_size)
            SZ_B: write_data = {4{req_wdata[7:0]}};
            SZ_H: write_data = {2{req_wdata[15:0]}};
            default: write_data = req_wdata;
         endcase
      end
   end

   lsu_load_align u_load_align (
      .i_rdata    (read_data),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_addr_lo  (r_addr_lo),
      .o_data     (w_load_data)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept)
               w_state_next = (w_mis | req_we) ? ST_RESP : ST_RD_WAIT;
            else if (cpu_wfi && r_rst_done)
               w_state_next = ST_SLEEP;
         end
         ST_RD_WAIT: w_state_next = ST_RESP;
         ST_RESP:    w_state_next = cpu_wfi ? ST_SLEEP : ST_IDLE;
         ST_SLEEP:   if (!cpu_wfi) w_state_next = ST_WAKE;
         ST_WAKE:    if (r_wake_cnt == '0) w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_rst_done <= 1'b0;
         r_rdata    <= 32'h0;
         r_err      <= 1'b0;
         r_wfi      <= 1'b0;
         r_size     <= SZ_B;
         r_unsigned <= 1'b0;
         r_addr_lo  <= 2'b00;
         r_wake_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_rst_done <= 1'b1;
         r_wfi      <= (w_state_next == ST_SLEEP);
         if (w_accept) begin
            r_rdata    <= 32'h0;
            r_err      <= w_mis;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr_lo  <= req_addr[1:0];
         end else if (r_state == ST_RD_WAIT) begin
            r_rdata <= w_load_data;
         end
         // Wake counter is loaded on standby exit and counts down to the IDLE hand-off.
         if (r_state == ST_SLEEP)
            r_wake_cnt <= WCW'(WAKE_CYCLES - 1);
         else if (r_state == ST_WAKE && r_wake_cnt != '0)
            r_wake_cnt <= r_wake_cnt - WCW'(1);
      end
   end

endmodule
